// File: rtl/mod_pow2_reduce.sv
// -----------------------------------------------------------------------------
// mod_pow2_reduce
//
// Word-serial power-of-two reducer. A DATA_W-bit operand X and an exponent k
// are captured on an accepted start. The block then produces either
// X mod 2^k (iMode=0) or floor(X / 2^k) (iMode=1). It writes one WORD_W-bit
// result word per clock into the output register.
//
// Timing: the start is sampled at edge E. The block runs NW = DATA_W/WORD_W
// cycles, then spends one DONE cycle with oDataValid high. oBusy covers the
// RUN and DONE cycles. A new start can be presented in the IDLE cycle that
// follows DONE.
//
// Optional build macro:
//   MOD_POW2_DISCARD_FLAG_EN - adds oDiscardNZ. The flag is high when the
//                              operation threw away a nonzero bit:
//                              bits >= k for remainder, bits < k for quotient.
//
// Ports:
//   iClk        clock, rising edge
//   iReset      synchronous active-high reset
//   iStart      start request, sampled only in IDLE
//   iMode       0 = remainder, 1 = quotient
//   iX          operand, captured on accepted start
//   iTwoexp     exponent k, captured on accepted start
//   oBusy       high from the cycle after accept through the oDataValid cycle
//   oDataValid  one-cycle result pulse
//   oZ          result register, held until the next accepted start or reset
//   oDiscardNZ  (optional) discarded-bits-nonzero flag, held with oZ
// -----------------------------------------------------------------------------
module mod_pow2_reduce #(
   parameter int unsigned DATA_W = 1024,
   parameter int unsigned WORD_W = 32,
   // Derived; sized so that k = DATA_W is representable.
   parameter int unsigned EXP_W  = $clog2(DATA_W) + 1
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iStart,
   input  logic              iMode,
   input  logic [DATA_W-1:0] iX,
   input  logic [EXP_W-1:0]  iTwoexp,
   output logic              oBusy,
   output logic              oDataValid,
   output logic [DATA_W-1:0] oZ
`ifdef MOD_POW2_DISCARD_FLAG_EN
   ,
   output logic              oDiscardNZ
`endif
);

   localparam int unsigned NW = DATA_W / WORD_W;
   localparam int unsigned JW = (NW > 1) ? $clog2(NW) : 1;
   localparam int unsigned RW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [JW-1:0]    LastIdx = JW'(NW - 1);
   localparam logic [EXP_W:0]   NwExt   = (EXP_W + 1)'(NW);
   localparam logic [WORD_W-1:0] OneW   = WORD_W'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] x_q, x_d;
   logic [EXP_W-1:0]  b_q, b_d;      // whole-word part of k (clamped to NW)
   logic [RW-1:0]     r_q, r_d;      // bit offset inside a word
   logic              mode_q, mode_d;
   logic [JW-1:0]     j_q, j_d;      // output word index
   logic [DATA_W-1:0] z_q, z_d;

   // Word view of the captured operand
   logic [WORD_W-1:0] x_words [NW];

   logic [EXP_W-1:0]  j_ext;
   logic [EXP_W:0]    idx_lo, idx_hi;
   logic [RW:0]       sh_hi;
   logic [WORD_W-1:0] lo_word, hi_word, mask, rem_word, quo_word, out_word;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (iStart) state_d = StRun;
         StRun:   if (j_q == LastIdx) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (decoded from registered state only)
   // ---------------------------------------------------------------------------
   always_comb begin
      oBusy      = 1'b0;
      oDataValid = 1'b0;
      unique case (state_q)
         StIdle:  ;
         StRun:   oBusy = 1'b1;
         StDone: begin
            oBusy      = 1'b1;
            oDataValid = 1'b1;
         end
         default: ;
      endcase
   end

   assign oZ = z_q;

   // ---------------------------------------------------------------------------
   // Word datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NW; i++) begin
         x_words[i] = x_q[i*WORD_W +: WORD_W];
      end
   end

   always_comb begin
      j_ext  = EXP_W'(j_q);
      idx_lo = {1'b0, b_q} + (EXP_W + 1)'(j_q);
      idx_hi = idx_lo + (EXP_W + 1)'(1);
      sh_hi  = (RW + 1)'(WORD_W) - {1'b0, r_q};

      // Source words past the top of X read as zero. This covers the
      // quotient's upper words and the clamped b = NW for k >= DATA_W.
      lo_word = (idx_lo < NwExt) ? x_words[idx_lo[JW-1:0]] : '0;
      hi_word = (idx_hi < NwExt) ? x_words[idx_hi[JW-1:0]] : '0;

      mask = (OneW << r_q) - OneW;

      if (j_ext < b_q) begin
         rem_word = x_words[j_q];
      end else if (j_ext == b_q) begin
         rem_word = x_words[j_q] & mask;
      end else begin
         rem_word = '0;
      end

      if (r_q == '0) begin
         quo_word = lo_word;
      end else begin
         quo_word = (lo_word >> r_q) | (hi_word << sh_hi);
      end

      out_word = mode_q ? quo_word : rem_word;
   end

   // ---------------------------------------------------------------------------
   // Capture and result assembly
   // ---------------------------------------------------------------------------
   always_comb begin
      x_d    = x_q;
      b_d    = b_q;
      r_d    = r_q;
      mode_d = mode_q;
      j_d    = j_q;
      z_d    = z_q;
      unique case (state_q)
         StIdle: begin
            if (iStart) begin
               x_d    = iX;
               mode_d = iMode;
               j_d    = '0;
               if (iTwoexp >= EXP_W'(DATA_W)) begin
                  // Keep every remainder word and shift every quotient word out.
                  b_d = EXP_W'(NW);
                  r_d = '0;
               end else begin
                  b_d = iTwoexp / EXP_W'(WORD_W);
                  r_d = RW'(iTwoexp % EXP_W'(WORD_W));
               end
            end
         end
         StRun: begin
            z_d[j_q*WORD_W +: WORD_W] = out_word;
            j_d = (j_q == LastIdx) ? '0 : j_q + JW'(1);
         end
         StDone:  ;
         default: ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         x_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         mode_q <= 1'b0;
         j_q    <= '0;
         z_q    <= '0;
      end else begin
         x_q    <= x_d;
         b_q    <= b_d;
         r_q    <= r_d;
         mode_q <= mode_d;
         j_q    <= j_d;
         z_q    <= z_d;
      end
   end

`ifdef MOD_POW2_DISCARD_FLAG_EN
   // ---------------------------------------------------------------------------
   // Discard flag: OR of the bits that word j throws away.
   // For quotient mode those are exactly the remainder bits of word j.
   // For remainder mode they are the bits of X[j] that the remainder drops.
   // ---------------------------------------------------------------------------
   logic              flag_q, flag_d;
   logic [WORD_W-1:0] disc_word;

   always_comb begin
      disc_word = mode_q ? rem_word : (x_words[j_q] ^ rem_word);
      flag_d    = flag_q;
      unique case (state_q)
         StIdle:  if (iStart) flag_d = 1'b0;
         StRun:   flag_d = flag_q | (|disc_word);
         StDone:  ;
         default: ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign oDiscardNZ = flag_q;
`endif

endmodule

// File: tb/tb_mod_pow2_reduce.sv
// -----------------------------------------------------------------------------
// tb_mod_pow2_reduce
//
// Directed bench for mod_pow2_reduce with default parameters. It applies
// hand-derived operand/exponent vectors and checks the reset state, results,
// latency, the handshake, ignored starts and an abort by reset. Builds with
// MOD_POW2_DISCARD_FLAG_EN also check oDiscardNZ.
// -----------------------------------------------------------------------------
module tb_mod_pow2_reduce;

   localparam int unsigned DATA_W = 1024;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned EXP_W  = 11;
   localparam int unsigned NW     = 32;

   logic              iClk = 1'b0;
   logic              iReset;
   logic              iStart;
   logic              iMode;
   logic [DATA_W-1:0] iX;
   logic [EXP_W-1:0]  iTwoexp;
   logic              oBusy;
   logic              oDataValid;
   logic [DATA_W-1:0] oZ;
`ifdef MOD_POW2_DISCARD_FLAG_EN
   logic              oDiscardNZ;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 iClk = ~iClk;

   mod_pow2_reduce dut (
      .iClk       (iClk),
      .iReset     (iReset),
      .iStart     (iStart),
      .iMode      (iMode),
      .iX         (iX),
      .iTwoexp    (iTwoexp),
      .oBusy      (oBusy),
      .oDataValid (oDataValid),
      .oZ         (oZ)
`ifdef MOD_POW2_DISCARD_FLAG_EN
      ,
      .oDiscardNZ (oDiscardNZ)
`endif
   );

   // Reports the lowest differing word so that each line stays short.
   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         for (int i = 0; i < NW; i++) begin
            if (got[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) begin
               $display("FAIL %s: word %0d is %h, expected %h", tag, i,
                        got[i*WORD_W +: WORD_W], exp[i*WORD_W +: WORD_W]);
               break;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // Accept one operation, then scramble the inputs and wait (bounded) for the result.
   task automatic run_op(input string tag, input logic mode, input logic [DATA_W-1:0] x,
                         input logic [EXP_W-1:0] k, input logic [DATA_W-1:0] exp_z,
                         input logic exp_flag);
      int lat;
      iStart  = 1'b1;
      iMode   = mode;
      iX      = x;
      iTwoexp = k;
      step();
      iStart  = 1'b0;
      iMode   = ~mode;
      iX      = ~x;
      iTwoexp = ~k;
      lat = 1;
      while (!oDataValid && lat < 200) begin
         step();
         lat++;
      end
      check({tag, "/latency"}, DATA_W'(lat), DATA_W'(33));
      check({tag, "/z"}, oZ, exp_z);
`ifdef MOD_POW2_DISCARD_FLAG_EN
      check({tag, "/flag"}, DATA_W'(oDiscardNZ), DATA_W'(exp_flag));
`endif
      step();
      check({tag, "/idle_after"}, DATA_W'({oBusy, oDataValid}), DATA_W'(2'b00));
   endtask

   logic [DATA_W-1:0] ones, xq, xa, e;
   int pulses;
   logic busy_gap;

   initial begin
      ones = '1;
      xq = '0;
      xq[64:0] = 65'h1_2345_6789_abcd_ef01;
      for (int i = 0; i < NW; i++) xa[i*WORD_W +: WORD_W] = 32'ha500_0000 | 32'(i);

      iReset = 1'b1; iStart = 1'b0; iMode = 1'b0; iX = '0; iTwoexp = '0;
      step(); step(); step();
      iReset = 1'b0;
      check("reset/busy", DATA_W'(oBusy), '0);
      check("reset/valid", DATA_W'(oDataValid), '0);
      check("reset/z", oZ, '0);
`ifdef MOD_POW2_DISCARD_FLAG_EN
      check("reset/flag", DATA_W'(oDiscardNZ), '0);
`endif

      // Remainder of all-ones by 2^100: words 0-2 all-ones, word 3 = 0xF.
      e = '0; e[99:0] = '1;
      run_op("rem_ones_k100", 1'b0, ones, 11'd100, e, 1'b1);
      // Quotient of all-ones by 2^100: 924 ones.
      e = '0; e[923:0] = '1;
      run_op("quo_ones_k100", 1'b1, ones, 11'd100, e, 1'b1);

      e = '0; e[31:0] = 32'h1234_5678;
      run_op("quo_k36", 1'b1, xq, 11'd36, e, 1'b1);
      e = '0; e[0] = 1'b1;
      run_op("quo_k64", 1'b1, xq, 11'd64, e, 1'b1);
      run_op("quo_k0", 1'b1, xq, 11'd0, xq, 1'b0);
      run_op("rem_k0", 1'b0, xa, 11'd0, '0, 1'b1);
      e = '0; e[63:0] = xa[63:0];
      run_op("rem_k64", 1'b0, xa, 11'd64, e, 1'b1);
      // k=40: word 0 kept, word 1 masked to its low byte (0xA5000001 -> 0x01).
      e = '0; e[31:0] = 32'ha500_0000; e[39:32] = 8'h01;
      run_op("rem_k40", 1'b0, xa, 11'd40, e, 1'b1);
      run_op("quo_k40", 1'b1, xa, 11'd40, xa >> 40, 1'b1);
      run_op("rem_k1024", 1'b0, xa, 11'd1024, xa, 1'b0);
      run_op("quo_k1024", 1'b1, xa, 11'd1024, '0, 1'b1);
      run_op("rem_k2047", 1'b0, xa, 11'd2047, xa, 1'b0);
      run_op("quo_k2047", 1'b1, xa, 11'd2047, '0, 1'b1);

      // Starts at cycles 5, 10 and 33 are ignored; the start at cycle 34 is accepted.
      iStart = 1'b1; iMode = 1'b0; iX = ones; iTwoexp = 11'd100;
      step();
      pulses = 0;
      busy_gap = 1'b0;
      for (int t = 1; t <= 34; t++) begin
         iStart  = (t == 5) || (t == 10) || (t == 33) || (t == 34);
         iMode   = 1'b1;
         iX      = ones;
         iTwoexp = 11'd100;
         if (oDataValid) pulses++;
         if (t <= 33 && !oBusy) busy_gap = 1'b1;
         if (t == 33) begin
            e = '0; e[99:0] = '1;
            check("busy/first_z", oZ, e);
         end
         if (t == 34) begin
            check("busy/idle_cycle", DATA_W'(oBusy), '0);
            e = '0; e[99:0] = '1;
            check("busy/z_held", oZ, e);
         end
         step();
      end
      iStart = 1'b0;
      check("busy/one_pulse", DATA_W'(pulses), DATA_W'(1));
      check("busy/no_gap", DATA_W'(busy_gap), '0);
      begin
         int lat;
         lat = 1;
         while (!oDataValid && lat < 200) begin
            step();
            lat++;
         end
         check("busy/second_latency", DATA_W'(lat), DATA_W'(33));
         e = '0; e[923:0] = '1;
         check("busy/second_z", oZ, e);
      end
      step();

      // Abort with a reset while RUN is on word 7.
      iStart = 1'b1; iMode = 1'b1; iX = xa; iTwoexp = 11'd40;
      step();
      iStart = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("abort/busy_before", DATA_W'(oBusy), DATA_W'(1));
      iReset = 1'b1;
      step();
      iReset = 1'b0;
      check("abort/busy", DATA_W'(oBusy), '0);
      check("abort/valid", DATA_W'(oDataValid), '0);
      check("abort/z", oZ, '0);
      run_op("abort/fresh", 1'b0, ones, 11'd100, ones >> 924, 1'b1);

`ifdef MOD_POW2_DISCARD_FLAG_EN
      e = '0; e[200] = 1'b1;
      run_op("flag_rem_k200", 1'b0, e, 11'd200, '0, 1'b1);
      e = '0; e[200] = 1'b1; e[0] = 1'b1;
      xa = '0; xa[192] = 1'b1;
      run_op("flag_quo_inexact", 1'b1, e, 11'd8, xa, 1'b1);
      e = '0; e[200] = 1'b1;
      run_op("flag_quo_exact", 1'b1, e, 11'd8, xa, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
